// File: rtl/sm_reg_dump_pkg.sv
// Shared definitions for the debug register dumper: FSM states, UART framing constants
// and the per-register byte selector.
package sm_reg_dump_pkg;

    typedef enum logic [2:0] {
        DmpIdle,
        DmpAddr,
        DmpWait,
        DmpCapt,
        DmpSend
    } dmpState_e;

    localparam logic        StartBit     = 1'b0;
    localparam logic        StopBit      = 1'b1;
    localparam int unsigned BitsPerFrame = 10;
    localparam int unsigned BytesPerReg  = 5;

    // Byte 0 carries the register index, bytes 1..4 the captured value MSB first.
    function automatic logic [7:0] frameByte(input logic [4:0]  idx,
                                             input logic [31:0] shadow,
                                             input logic [2:0]  cnt);
        logic [7:0] b;
        case (cnt)
            3'd0:    b = {3'b000, idx};
            3'd1:    b = shadow[31:24];
            3'd2:    b = shadow[23:16];
            3'd3:    b = shadow[15:8];
            default: b = shadow[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sm_uart_tx.sv
// UART 8N1 transmitter with a valid/ready byte interface; ready rises in the final
// stop-bit cycle so consecutive bytes leave with no gap.
module sm_uart_tx
    import sm_reg_dump_pkg::*;
#(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int unsigned      TimerW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TimerW-1:0] TimerLoad = TimerW'(CLK_DIV - 1);
    localparam logic [3:0]        LastBit   = 4'(BitsPerFrame - 1);

    logic              activeQ, activeD;
    logic [3:0]        bitCntQ, bitCntD;
    logic [TimerW-1:0] timerQ, timerD;
    logic [8:0]        shiftQ, shiftD;
    logic              txQ, txD;

    always_comb begin
        activeD = activeQ;
        bitCntD = bitCntQ;
        timerD  = timerQ;
        shiftD  = shiftQ;
        txD     = txQ;
        ready   = !activeQ || (bitCntQ == LastBit && timerQ == '0);

        if (valid && ready) begin
            activeD = 1'b1;
            bitCntD = '0;
            timerD  = TimerLoad;
            shiftD  = {StopBit, data};
            txD     = StartBit;
        end else if (activeQ) begin
            if (timerQ == '0) begin
                if (bitCntQ == LastBit) begin
                    activeD = 1'b0;
                end else begin
                    bitCntD = bitCntQ + 4'd1;
                    timerD  = TimerLoad;
                    txD     = shiftQ[0];
                    shiftD  = {1'b1, shiftQ[8:1]};
                end
            end else begin
                timerD = timerQ - TimerW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            activeQ <= 1'b0;
            bitCntQ <= '0;
            timerQ  <= '0;
            shiftQ  <= '1;
            txQ     <= StopBit;
        end else begin
            activeQ <= activeD;
            bitCntQ <= bitCntD;
            timerQ  <= timerD;
            shiftQ  <= shiftD;
            txQ     <= txD;
        end
    end

    assign tx = txQ;

endmodule

// File: rtl/sm_reg_dump.sv
// Debug register dumper: walks FIRST_REG..LAST_REG on the CPU debug port and streams
// each index plus 32-bit value out over UART.
module sm_reg_dump
    import sm_reg_dump_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 16,
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [5:0] FirstIdx = 6'(FIRST_REG);
    localparam logic [5:0] LastIdx  = 6'(LAST_REG);
    localparam logic [2:0] AllSent  = 3'(BytesPerReg);

    dmpState_e   stateQ, stateD;
    logic [5:0]  idxQ, idxD, idxNext;
    logic [4:0]  regAddrQ, regAddrD;
    logic [31:0] shadowQ, shadowD;
    logic [2:0]  byteCntQ, byteCntD;
    logic        busyQ, busyD;
    logic        doneQ, doneD;
    logic        byteValid, byteReady;

    assign idxNext = idxQ + 6'd1;

    always_comb begin
        stateD    = stateQ;
        idxD      = idxQ;
        regAddrD  = regAddrQ;
        shadowD   = shadowQ;
        byteCntD  = byteCntQ;
        busyD     = busyQ;
        doneD     = 1'b0;
        byteValid = 1'b0;

        unique case (stateQ)
            DmpIdle: begin
                if (start) begin
                    stateD = DmpAddr;
                    idxD   = FirstIdx;
                    busyD  = 1'b1;
                end
            end
            DmpAddr: begin
                regAddrD = idxQ[4:0];
                stateD   = DmpWait;
            end
            DmpWait: stateD = DmpCapt;
            DmpCapt: begin
                shadowD  = regData;
                byteCntD = '0;
                stateD   = DmpSend;
            end
            DmpSend: begin
                if (byteCntQ != AllSent) begin
                    byteValid = 1'b1;
                    if (byteReady) byteCntD = byteCntQ + 3'd1;
                end else if (byteReady) begin
                    if (idxQ == LastIdx) begin
                        stateD = DmpIdle;
                        busyD  = 1'b0;
                        doneD  = 1'b1;
                    end else begin
                        // Address step folded into the final stop-bit cycle, leaving
                        // three idle tx clocks between consecutive register frames.
                        idxD     = idxNext;
                        regAddrD = idxNext[4:0];
                        stateD   = DmpWait;
                    end
                end
            end
            default: stateD = DmpIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ   <= DmpIdle;
            idxQ     <= '0;
            regAddrQ <= '0;
            shadowQ  <= '0;
            byteCntQ <= '0;
            busyQ    <= 1'b0;
            doneQ    <= 1'b0;
        end else begin
            stateQ   <= stateD;
            idxQ     <= idxD;
            regAddrQ <= regAddrD;
            shadowQ  <= shadowD;
            byteCntQ <= byteCntD;
            busyQ    <= busyD;
            doneQ    <= doneD;
        end
    end

    sm_uart_tx #(
        .CLK_DIV (CLK_DIV)
    ) uUartTx (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (frameByte(idxQ[4:0], shadowQ, byteCntQ)),
        .valid (byteValid),
        .ready (byteReady),
        .tx    (tx)
    );

    assign regAddr = regAddrQ;
    assign busy    = busyQ;
    assign done    = doneQ;

endmodule
